// File: rtl/sigdel_decim.sv
// Second-order CIC (sinc2) decimator: 1-bit sigma-delta bitstream in, 8-bit
// saturated samples out, one result per R = 2^LOG2R enabled input samples.
module sigdel_decim #(
    parameter int LOG2R = 4,
    parameter int W     = 2 * LOG2R + 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_in,
    input  logic       bit_en,
    output logic [7:0] data_out,
    output logic       data_valid
);

    // Flow control: bit_en qualifies bit_in on each rising edge (no backpressure);
    // data_valid is a one-clock strobe and data_out holds its value between strobes.

    localparam int SH = 2 * LOG2R - 8;

    typedef enum logic [1:0] {
        PRIME0 = 2'd0,
        PRIME1 = 2'd1,
        RUN    = 2'd2
    } state_t;

    logic [W-1:0]     i1, i2, d1, d2;
    logic [W-1:0]     c1, c2, y;
    logic [7:0]       y_sat;
    logic [LOG2R-1:0] cnt;
    logic             stb;
    logic             load_out;
    state_t           state_q, state_d;

    // Comb differences rely on modulo-2^W wrap, so the integrators may overflow freely.
    always_comb begin
        c1    = i2 - d1;
        c2    = c1 - d2;
        y     = c2 >> SH;
        y_sat = (|y[W-1:8]) ? 8'hFF : y[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1  <= '0;
            i2  <= '0;
            cnt <= '0;
            stb <= 1'b0;
        end else begin
            stb <= bit_en && (&cnt);
            if (bit_en) begin
                i1  <= i1 + {{(W-1){1'b0}}, bit_in};
                i2  <= i2 + i1;
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1 <= '0;
            d2 <= '0;
        end else if (stb) begin
            d1 <= i2;
            d2 <= c1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PRIME0;
        end else begin
            state_q <= state_d;
        end
    end

    // The first two decimated results still carry the start-up transient.
    always_comb begin
        state_d  = state_q;
        load_out = 1'b0;
        if (stb) begin
            case (state_q)
                PRIME0:  state_d = PRIME1;
                PRIME1:  state_d = RUN;
                RUN:     load_out = 1'b1;
                default: state_d = PRIME0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= 8'd0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= load_out;
            if (load_out) begin
                data_out <= y_sat;
            end
        end
    end

endmodule
